aes_key_schedule_engine: RTL

- Iterative, word-serial AES key-expansion engine for AES-128, AES-192 and AES-256, selected at run time.
- Expands the cipher key into all round keys (11/13/15 x 128 bit) and holds them in internal storage.
- The cipher datapath reads them through a registered random-access port.
- Replaces the per-round single-step key generator; lets round-key consumption overlap expansion via a running availability count.

---
 rtl/aes_key_schedule_engine_if.sv | 32 +++
 rtl/aes_key_schedule_engine.sv | 153 +++++++++++++++
 2 files changed

// File: rtl/aes_key_schedule_engine_if.sv
// aes_key_schedule_engine_if: start/key/status and round-key read bus of the AES key schedule engine.
// The zeroize signal exists only when AES_KEY_ZEROIZE_EN is defined.
interface aes_key_schedule_engine_if;
  logic         start;
  logic [1:0]   mode;
  logic [255:0] key_in;
  logic         busy;
  logic         done;
  logic         keys_valid;
  logic         err;
  logic [3:0]   rk_avail;
  logic [3:0]   nr;
  logic [3:0]   rk_addr;
  logic [127:0] rk_data;
`ifdef AES_KEY_ZEROIZE_EN
  logic         zeroize;
`endif
  modport slave (
`ifdef AES_KEY_ZEROIZE_EN
    input  zeroize,
`endif
    input  start, mode, key_in, rk_addr,
    output busy, done, keys_valid, err, rk_avail, nr, rk_data
  );
  modport master (
`ifdef AES_KEY_ZEROIZE_EN
    output zeroize,
`endif
    output start, mode, key_in, rk_addr,
    input  busy, done, keys_valid, err, rk_avail, nr, rk_data
  );
endinterface

// File: rtl/aes_key_schedule_engine.sv
// aes_key_schedule_engine: word-serial AES-128/192/256 key expansion into local storage with a registered read port.
// Define AES_KEY_ZEROIZE_EN to add the zeroize input, which also makes rst clear the key storage.
module FORWARD_SUBSTITUTION_BOX (
  input  logic       clk,
  input  logic [7:0] i_din,
  output logic [7:0] o_dout
);
  logic [7:0] r_dout;
  function automatic logic [7:0] gmul(input logic [7:0] a, input logic [7:0] b);
    logic [7:0] p, x;
    p = 8'h00;
    x = a;
    for (int k = 0; k < 8; k++) begin
      p = b[k] ? p ^ x : p;
      x = {x[6:0], 1'b0} ^ (x[7] ? 8'h1b : 8'h00);
    end
    return p;
  endfunction
  // GF(2^8) inverse as x^254, then the affine transform
  function automatic logic [7:0] sbox(input logic [7:0] a);
    logic [7:0] s, r;
    s = a;
    r = 8'h01;
    for (int k = 1; k < 8; k++) begin
      s = gmul(s, s);
      r = gmul(r, s);
    end
    return r ^ {r[6:0], r[7]} ^ {r[5:0], r[7:6]} ^ {r[4:0], r[7:5]} ^ {r[3:0], r[7:4]} ^ 8'h63;
  endfunction
  always_ff @(posedge clk) r_dout <= sbox(i_din);
  assign o_dout = r_dout;
endmodule

module aes_key_schedule_engine #(
  parameter int MAX_KEY_BITS = 256
) (
  input logic clk,
  input logic rst,
  aes_key_schedule_engine_if.slave bus
);
  localparam int NR_MAX = MAX_KEY_BITS / 32 + 6;
  localparam int NW_MAX = 4 * (NR_MAX + 1);
  typedef enum logic [2:0] {S_IDLE, S_LOAD, S_CALC, S_SUBW, S_DONE} state_t;
  state_t       r_state, w_next;
  logic [31:0]  r_mem [NW_MAX];
  logic [31:0]  r_win [8];
  logic [255:0] r_key;
  logic [3:0]   r_nk, r_nr;
  logic [5:0]   r_last, r_i, r_wcnt;
  logic [2:0]   r_j;
  logic [7:0]   r_rcon;
  logic         r_keys_valid, r_err;
  logic [127:0] r_rk_data;
  logic         w_ill, w_go, w_sub, w_wr, w_zero, w_busy, w_done, w_rd_ok;
  logic [31:0]  w_prev, w_old, w_sb_in, w_sb_out, w_word;
  logic [255:0] w_ks;
  logic [5:0]   w_base;
`ifdef AES_KEY_ZEROIZE_EN
  assign w_zero = bus.zeroize;
`else
  assign w_zero = 1'b0;
`endif
  assign w_ill   = bus.mode == 2'd3 || (bus.mode == 2'd1 && MAX_KEY_BITS < 192) ||
                   (bus.mode == 2'd2 && MAX_KEY_BITS < 256);
  assign w_go    = r_state == S_IDLE && bus.start && !w_ill;
  assign w_sub   = r_j == 3'd0 || (r_nk == 4'd8 && r_j == 3'd4);
  // r_win[7] is w[i-1]; w[i-Nk] sits Nk-1 slots below it
  assign w_prev  = r_win[7];
  assign w_old   = r_win[3'(4'd8 - r_nk)];
  assign w_sb_in = r_j == 3'd0 ? {w_prev[23:0], w_prev[31:24]} : w_prev;
  assign w_word  = w_old ^ (r_state == S_SUBW ? w_sb_out ^ {r_j == 3'd0 ? r_rcon : 8'h00, 24'h0} : w_prev);
  assign w_wr    = (r_state == S_CALC && !w_sub) || r_state == S_SUBW;
  assign w_ks    = r_key >> {4'd8 - r_nk, 5'd0};
  assign w_base  = {bus.rk_addr, 2'b00};
  assign w_rd_ok = bus.rk_addr <= r_nr && bus.rk_addr < r_wcnt[5:2];
  for (genvar b = 0; b < 4; b++) begin : g_sbox
    FORWARD_SUBSTITUTION_BOX u_sbox (.clk(clk), .i_din(w_sb_in[8*b +: 8]), .o_dout(w_sb_out[8*b +: 8]));
  end
  always_ff @(posedge clk) r_state <= rst ? S_IDLE : w_next;
  always_comb begin
    w_busy = r_state == S_LOAD || r_state == S_CALC || r_state == S_SUBW;
    w_done = r_state == S_DONE;
    w_next = w_zero ? S_IDLE :
             r_state == S_IDLE ? (w_go ? S_LOAD : S_IDLE) :
             r_state == S_LOAD ? S_CALC :
             r_state == S_DONE ? S_IDLE :
             (r_state == S_CALC && w_sub) ? S_SUBW :
             r_i == r_last ? S_DONE : S_CALC;
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      r_err <= 1'b0;
      r_nr <= 4'd0;
      r_keys_valid <= 1'b0;
      r_wcnt <= 6'd0;
    end else if (w_zero) begin
      r_keys_valid <= 1'b0;
      r_wcnt <= 6'd0;
      for (int k = 0; k < 8; k++) r_win[k] <= 32'h0;
    end else begin
      if (r_state == S_IDLE && bus.start) begin
        r_err <= w_ill;
        r_keys_valid <= 1'b0;
        r_wcnt <= 6'd0;
        if (!w_ill) begin
          r_key <= bus.key_in;
          r_nk <= 4'd4 + {1'b0, bus.mode, 1'b0};
          r_nr <= 4'd10 + {1'b0, bus.mode, 1'b0};
          r_last <= {4'd10 + {1'b0, bus.mode, 1'b0}, 2'b11};
        end
      end
      if (r_state == S_LOAD) begin
        r_wcnt <= {2'b00, r_nk};
        r_i <= {2'b00, r_nk};
        r_j <= 3'd0;
        r_rcon <= 8'h01;
        for (int k = 0; k < 8; k++) r_win[k] <= w_ks[255 - 32*k -: 32];
      end
      if (w_wr) begin
        r_wcnt <= r_wcnt + 6'd1;
        r_i <= r_i + 6'd1;
        r_j <= r_j == 3'(r_nk - 4'd1) ? 3'd0 : r_j + 3'd1;
        r_rcon <= r_j == 3'd0 ? {r_rcon[6:0], 1'b0} ^ (r_rcon[7] ? 8'h1b : 8'h00) : r_rcon;
        for (int k = 0; k < 7; k++) r_win[k] <= r_win[k+1];
        r_win[7] <= w_word;
        r_keys_valid <= r_i == r_last;
      end
    end
  end
  always_ff @(posedge clk) begin
`ifdef AES_KEY_ZEROIZE_EN
    if (rst || bus.zeroize) begin
      for (int k = 0; k < NW_MAX; k++) r_mem[k] <= 32'h0;
    end else
`endif
    if (r_state == S_LOAD) begin
      for (int k = 0; k < 8; k++) if (4'(k) < r_nk) r_mem[6'(k)] <= r_key[255 - 32*k -: 32];
    end else if (w_wr) begin
      r_mem[r_i] <= w_word;
    end
  end
  always_ff @(posedge clk) begin
    if (rst || w_zero) r_rk_data <= 128'h0;
    else r_rk_data <= w_rd_ok ? {r_mem[w_base], r_mem[w_base + 6'd1], r_mem[w_base + 6'd2], r_mem[w_base + 6'd3]} : 128'h0;
  end
  assign bus.busy       = w_busy;
  assign bus.done       = w_done;
  assign bus.keys_valid = r_keys_valid;
  assign bus.err        = r_err;
  assign bus.rk_avail   = r_wcnt[5:2];
  assign bus.nr         = r_nr;
  assign bus.rk_data    = r_rk_data;
endmodule
